// File: rtl/mbus_sleep_req_gen_pkg.sv
// Shared types and constants for the MBus sleep-request generator.
// State encodings, isolation levels and a terminal-count helper.
package mbus_sleep_req_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_GUARD = 3'd2,
    ST_REQ   = 3'd3,
    ST_ACKED = 3'd4
  } state_t;

  localparam logic IO_HOLD    = 1'b1;
  localparam logic IO_RELEASE = 1'b0;

  function automatic int term_of(int n);
    return (n > 0) ? n - 1 : 0;
  endfunction

endpackage

// File: rtl/mbus_sleep_req_gen_if.sv
// Handshake bundle between the bus controller side and the
// sleep-request generator.
interface mbus_sleep_req_gen_if;

  logic SLEEP_CMD;
  logic BUS_IDLE;
  logic INT_PEND;
  logic MBC_ISOLATE;
  logic SLEEP_REQ;
  logic SLEEP_ABORT;
  logic SLEEP_PENDING;

  modport master (
    output SLEEP_CMD,
    output BUS_IDLE,
    output INT_PEND,
    output MBC_ISOLATE,
    input  SLEEP_REQ,
    input  SLEEP_ABORT,
    input  SLEEP_PENDING
  );

  modport slave (
    input  SLEEP_CMD,
    input  BUS_IDLE,
    input  INT_PEND,
    input  MBC_ISOLATE,
    output SLEEP_REQ,
    output SLEEP_ABORT,
    output SLEEP_PENDING
  );

endinterface

// File: rtl/mbus_sleep_guard_cnt.sv
// Saturating cycle counter with clear, enable and terminal compare,
// shared by the guard interval and the acknowledge timeout.
module mbus_sleep_guard_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             at_term
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/mbus_sleep_req_gen.sv
// Qualified, registered SLEEP_REQ generator for the MBus sleep controller.
// Optional acknowledge timeout: define MBUS_SLEEP_REQ_TIMEOUT_EN.
module mbus_sleep_req_gen
  import mbus_sleep_req_gen_pkg::*;
#(
  parameter int GUARD_CYCLES   = 4,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 12
) (
  input  logic                 MBUS_CLKIN,
  input  logic                 RESETn,
  mbus_sleep_req_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] G_TERM =
    CNT_W'(term_of(GUARD_CYCLES));
  localparam logic [CNT_W-1:0] T_TERM =
    CNT_W'(term_of(TIMEOUT_CYCLES));

  state_t           state;
  logic             req_q;
  logic             abort_q;
  logic             pend_q;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_term;
  logic             at_term;
  logic             ack;
  logic             rel;

  assign ack = (bus.MBC_ISOLATE == IO_HOLD);
  assign rel = (bus.MBC_ISOLATE == IO_RELEASE);

  // Counter sits cleared outside GUARD/REQ so each entry starts at 0.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    cnt_term = G_TERM;
    case (state)
      ST_GUARD: begin
        cnt_clr = !bus.BUS_IDLE || at_term;
        cnt_en  = 1'b1;
      end
      ST_REQ: begin
        cnt_term = T_TERM;
`ifdef MBUS_SLEEP_REQ_TIMEOUT_EN
        cnt_en   = 1'b1;
`else
        cnt_clr  = 1'b1;
`endif
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  mbus_sleep_guard_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (MBUS_CLKIN),
    .rst_n   (RESETn),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .term    (cnt_term),
    .at_term (at_term)
  );

  always_ff @(posedge MBUS_CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      state   <= ST_IDLE;
      req_q   <= 1'b0;
      abort_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.SLEEP_CMD) begin
            if (bus.INT_PEND) begin
              abort_q <= 1'b1;
            end else begin
              state  <= ST_ARMED;
              pend_q <= 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (bus.INT_PEND) begin
            state   <= ST_IDLE;
            abort_q <= 1'b1;
            pend_q  <= 1'b0;
          end else if (bus.BUS_IDLE) begin
            if (GUARD_CYCLES == 0) begin
              state <= ST_REQ;
              req_q <= 1'b1;
            end else begin
              state <= ST_GUARD;
            end
          end
        end
        ST_GUARD: begin
          if (bus.INT_PEND) begin
            state   <= ST_IDLE;
            abort_q <= 1'b1;
            pend_q  <= 1'b0;
          end else if (!bus.BUS_IDLE) begin
            state <= ST_ARMED;
          end else if (at_term) begin
            state <= ST_REQ;
            req_q <= 1'b1;
          end
        end
        ST_REQ: begin
          // Committed: interrupts no longer cancel the request.
          if (ack) begin
            state <= ST_ACKED;
            req_q <= 1'b0;
          end
`ifdef MBUS_SLEEP_REQ_TIMEOUT_EN
          else if (at_term) begin
            state   <= ST_IDLE;
            req_q   <= 1'b0;
            abort_q <= 1'b1;
            pend_q  <= 1'b0;
          end
`endif
        end
        ST_ACKED: begin
          if (rel) begin
            state  <= ST_IDLE;
            pend_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          req_q  <= 1'b0;
          pend_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SLEEP_REQ     = req_q;
  assign bus.SLEEP_ABORT   = abort_q;
  assign bus.SLEEP_PENDING = pend_q;

endmodule

// File: tb/tb_mbus_sleep_req_gen.sv
// Bench for mbus_sleep_req_gen: GUARD_CYCLES=4 and =0 instances
// driven in parallel, checked against a phase/run-length model.
`timescale 1ns/100ps
module tb_mbus_sleep_req_gen;
  import mbus_sleep_req_gen_pkg::*;

  localparam int TO = 12;
`ifdef MBUS_SLEEP_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd = 1'b0;
  logic idle = 1'b1;
  logic intp = 1'b0;
  logic iso = IO_RELEASE;

  mbus_sleep_req_gen_if i4 ();
  mbus_sleep_req_gen_if i0 ();

  assign i4.SLEEP_CMD   = cmd;
  assign i4.BUS_IDLE    = idle;
  assign i4.INT_PEND    = intp;
  assign i4.MBC_ISOLATE = iso;
  assign i0.SLEEP_CMD   = cmd;
  assign i0.BUS_IDLE    = idle;
  assign i0.INT_PEND    = intp;
  assign i0.MBC_ISOLATE = iso;

  mbus_sleep_req_gen #(
    .GUARD_CYCLES (4), .CNT_W (4), .TIMEOUT_CYCLES (TO)
  ) u4 (.MBUS_CLKIN (clk), .RESETn (rst_n), .bus (i4));

  mbus_sleep_req_gen #(
    .GUARD_CYCLES (0), .CNT_W (4), .TIMEOUT_CYCLES (TO)
  ) u0 (.MBUS_CLKIN (clk), .RESETn (rst_n), .bus (i0));

  always #5 clk = ~clk;

  // phase: 0 nothing, 1 waiting for idle run, 2 requesting, 3 asleep
  typedef struct {
    int phase;
    int idle_run;
    int age;
    bit abort;
  } mdl_t;

  mdl_t m4, m0;
  int   edge_no = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic mdl_t step(mdl_t m, int g, logic c,
                                logic bi, logic ip, logic is);
    mdl_t n = m;
    n.abort = 1'b0;
    if (m.phase == 0) begin
      if (c && ip) n.abort = 1'b1;
      else if (c) begin
        n.phase = 1;
        n.idle_run = 0;
      end
    end else if (m.phase == 1) begin
      if (ip) begin
        n.phase = 0;
        n.abort = 1'b1;
      end else if (bi) begin
        n.idle_run = m.idle_run + 1;
        if (n.idle_run == g + 1) begin
          n.phase = 2;
          n.age = 0;
        end
      end else begin
        n.idle_run = 0;
      end
    end else if (m.phase == 2) begin
      if (is == IO_HOLD) n.phase = 3;
      else if (TO_EN) begin
        n.age = m.age + 1;
        if (n.age == TO) begin
          n.phase = 0;
          n.abort = 1'b1;
        end
      end
    end else begin
      if (is == IO_RELEASE) n.phase = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 <= '{0, 0, 0, 1'b0};
      m0 <= '{0, 0, 0, 1'b0};
    end else begin
      edge_no <= edge_no + 1;
      m4 <= step(m4, 4, cmd, idle, intp, iso);
      m0 <= step(m0, 0, cmd, idle, intp, iso);
    end
  end

  task automatic chk(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0b want %0b @edge %0d",
               name, act, exp, edge_no);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && edge_no > 0) begin
      chk("m4_req",   i4.SLEEP_REQ,     m4.phase == 2);
      chk("m4_abort", i4.SLEEP_ABORT,   m4.abort);
      chk("m4_pend",  i4.SLEEP_PENDING, m4.phase != 0);
      chk("m0_req",   i0.SLEEP_REQ,     m0.phase == 2);
      chk("m0_abort", i0.SLEEP_ABORT,   m0.abort);
      chk("m0_pend",  i0.SLEEP_PENDING, m0.phase != 0);
    end
  end

  // Returns at the falling edge that follows rising edge k.
  task automatic upto(int k);
    while (edge_no < k) @(negedge clk);
  endtask

  task automatic pulse_cmd(int k);
    upto(k - 1);
    cmd = 1'b1;
    upto(k);
    cmd = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog edge %0d", edge_no);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_req4",   i4.SLEEP_REQ,     1'b0);
    chk("rst_abort4", i4.SLEEP_ABORT,   1'b0);
    chk("rst_pend4",  i4.SLEEP_PENDING, 1'b0);
    chk("rst_req0",   i0.SLEEP_REQ,     1'b0);
    #10 rst_n = 1'b1;

    // basic request and acknowledge
    pulse_cmd(10);
    chk("s1_pend4", i4.SLEEP_PENDING, 1'b1);
    chk("s1_req0_10", i0.SLEEP_REQ, 1'b0);
    upto(11);
    chk("s1_req0_11", i0.SLEEP_REQ, 1'b1);
    upto(14);
    chk("s1_req4_14", i4.SLEEP_REQ, 1'b0);
    upto(15);
    chk("s1_req4_15", i4.SLEEP_REQ, 1'b1);
    upto(16);
    iso = IO_HOLD;
    upto(17);
    chk("s1_ack4", i4.SLEEP_REQ, 1'b0);
    chk("s1_ack0", i0.SLEEP_REQ, 1'b0);
    chk("s1_slp4", i4.SLEEP_PENDING, 1'b1);
    upto(19);
    iso = IO_RELEASE;
    upto(20);
    chk("s1_wake4", i4.SLEEP_PENDING, 1'b0);

    // bus activity restarts the guard
    pulse_cmd(40);
    upto(42);
    idle = 1'b0;
    upto(43);
    idle = 1'b1;
    upto(47);
    chk("s2_req4_47", i4.SLEEP_REQ, 1'b0);
    upto(48);
    chk("s2_req4_48", i4.SLEEP_REQ, 1'b1);
    upto(49);
    iso = IO_HOLD;
    upto(52);
    iso = IO_RELEASE;

    // interrupt during guard aborts; committed request ignores it
    pulse_cmd(70);
    upto(71);
    intp = 1'b1;
    upto(72);
    chk("s3_abort4", i4.SLEEP_ABORT, 1'b1);
    chk("s3_pend4",  i4.SLEEP_PENDING, 1'b0);
    chk("s3_req4",   i4.SLEEP_REQ, 1'b0);
    chk("s3_req0",   i0.SLEEP_REQ, 1'b1);
    intp = 1'b0;
    upto(73);
    chk("s3_abort4_off", i4.SLEEP_ABORT, 1'b0);
    upto(74);
    iso = IO_HOLD;
    upto(76);
    iso = IO_RELEASE;
    upto(79);
    cmd = 1'b1;
    intp = 1'b1;
    upto(80);
    cmd = 1'b0;
    intp = 1'b0;
    chk("s3_idle_abort4", i4.SLEEP_ABORT, 1'b1);
    chk("s3_idle_abort0", i0.SLEEP_ABORT, 1'b1);
    chk("s3_idle_pend0",  i0.SLEEP_PENDING, 1'b0);

    // ignored commands and interrupts once committed
    pulse_cmd(110);
    pulse_cmd(112);
    upto(115);
    chk("s4_req4", i4.SLEEP_REQ, 1'b1);
    intp = 1'b1;
    upto(117);
    intp = 1'b0;
    chk("s4_req4_int", i4.SLEEP_REQ, 1'b1);
    iso = IO_HOLD;
    pulse_cmd(119);
    upto(120);
    iso = IO_RELEASE;
    upto(121);
    chk("s4_wake4", i4.SLEEP_PENDING, 1'b0);
    upto(123);
    chk("s4_noq_pend4", i4.SLEEP_PENDING, 1'b0);
    chk("s4_noq_req4",  i4.SLEEP_REQ, 1'b0);

    // no acknowledge: timeout if built in, otherwise held
    pulse_cmd(150);
    upto(162);
    chk("s5_req0_162", i0.SLEEP_REQ, 1'b1);
    upto(163);
    chk("s5_req0_163", i0.SLEEP_REQ, !TO_EN);
    chk("s5_abort0",   i0.SLEEP_ABORT, TO_EN);
    upto(166);
    chk("s5_req4_166", i4.SLEEP_REQ, 1'b1);
    upto(167);
    chk("s5_req4_167", i4.SLEEP_REQ, !TO_EN);
    chk("s5_abort4",   i4.SLEEP_ABORT, TO_EN);
    chk("s5_pend4",    i4.SLEEP_PENDING, !TO_EN);
    upto(168);
    chk("s5_abort4_off", i4.SLEEP_ABORT, 1'b0);
    upto(169);
    iso = IO_HOLD;
    upto(172);
    iso = IO_RELEASE;

    // asynchronous reset mid-request, then normal timing
    pulse_cmd(190);
    upto(196);
    chk("s6_req4_pre", i4.SLEEP_REQ, 1'b1);
    #1 rst_n = 1'b0;
    #0.5;
    chk("s6_rst_req4",   i4.SLEEP_REQ, 1'b0);
    chk("s6_rst_pend4",  i4.SLEEP_PENDING, 1'b0);
    chk("s6_rst_abort4", i4.SLEEP_ABORT, 1'b0);
    chk("s6_rst_req0",   i0.SLEEP_REQ, 1'b0);
    #0.5 rst_n = 1'b1;
    pulse_cmd(200);
    upto(201);
    chk("s6_req0_201", i0.SLEEP_REQ, 1'b1);
    upto(204);
    chk("s6_req4_204", i4.SLEEP_REQ, 1'b0);
    upto(205);
    chk("s6_req4_205", i4.SLEEP_REQ, 1'b1);
    upto(206);
    iso = IO_HOLD;
    upto(208);
    iso = IO_RELEASE;
    upto(212);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
